// File: rtl/atm_keypad_entry.sv
// ---------------------------------------------------------------------------
// atm_keypad_entry
//
// Input stage of the ATM controller. Collects BCD keypad strokes and assembles
// the packed account number, password and withdrawal amount fields for the
// ATM core. Each field is released with a one-cycle valid pulse.
//
// Optional feature macro: ATM_KEY_TIMEOUT_EN
//   When defined, an inactivity counter aborts a partially entered
//   transaction after TIMEOUT_CYC idle cycles and pulses `timeout`.
//   When undefined, there is no counter and `timeout` is tied to 0.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   key_valid  in   1      one-cycle strobe: key_code is valid
//   key_code   in   4      0-9 digit, A=clear, B=enter, C=cancel, D-F ignored
//   useractno  out  4*ACCT_DIGITS  packed BCD account number, MS digit on top
//   userpswd   out  4*PSWD_DIGITS  packed BCD password
//   useramt    out  4*AMT_DIGITS   packed BCD amount, right-aligned
//   acct_vld   out  1      one-cycle pulse: useractno updated
//   pswd_vld   out  1      one-cycle pulse: userpswd updated
//   amt_vld    out  1      one-cycle pulse: useramt updated
//   entry_err  out  1      one-cycle pulse: enter with too few digits
//   timeout    out  1      one-cycle pulse: inactivity abort
//   phase      out  2      0=ACCT, 1=PSWD, 2=AMT
// ---------------------------------------------------------------------------
module atm_keypad_entry #(
  parameter int ACCT_DIGITS = 4,
  parameter int PSWD_DIGITS = 2,
  parameter int AMT_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic [4*ACCT_DIGITS-1:0] useractno,
  output logic [4*PSWD_DIGITS-1:0] userpswd,
  output logic [4*AMT_DIGITS-1:0]  useramt,
  output logic                     acct_vld,
  output logic                     pswd_vld,
  output logic                     amt_vld,
  output logic                     entry_err,
  output logic                     timeout,
  output logic [1:0]               phase
);

  // The shift buffer is shared by all three fields, so it is sized for the
  // widest one. It is cleared at every field boundary and the digit count is
  // capped at the current field's width, so bits above the current field
  // stay zero and a plain low-order slice yields the field.
  localparam int MAX_AB     = (ACCT_DIGITS > PSWD_DIGITS) ? ACCT_DIGITS : PSWD_DIGITS;
  localparam int MAX_DIGITS = (MAX_AB > AMT_DIGITS) ? MAX_AB : AMT_DIGITS;
  localparam int BUF_W      = 4 * MAX_DIGITS;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    PH_ACCT = 2'd0,
    PH_PSWD = 2'd1,
    PH_AMT  = 2'd2
  } phase_t;

  phase_t             phase_reg;
  logic [BUF_W-1:0]   shift_buf;
  logic [CNT_W-1:0]   digit_cnt;
  logic [CNT_W-1:0]   field_limit;
  logic               is_digit;
  logic               expire;

  assign is_digit = (key_code <= 4'd9);
  assign phase    = phase_reg;

  always_comb begin
    field_limit = '0;
    case (phase_reg)
      PH_ACCT: field_limit = CNT_W'(ACCT_DIGITS);
      PH_PSWD: field_limit = CNT_W'(PSWD_DIGITS);
      PH_AMT:  field_limit = CNT_W'(AMT_DIGITS);
      default: field_limit = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= PH_ACCT;
      shift_buf <= '0;
      digit_cnt <= '0;
      useractno <= '0;
      userpswd  <= '0;
      useramt   <= '0;
      acct_vld  <= 1'b0;
      pswd_vld  <= 1'b0;
      amt_vld   <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      acct_vld  <= 1'b0;
      pswd_vld  <= 1'b0;
      amt_vld   <= 1'b0;
      entry_err <= 1'b0;

      if (!(phase_reg inside {PH_ACCT, PH_PSWD, PH_AMT})) begin
        // Unused encoding: fall back to the start of a transaction.
        phase_reg <= PH_ACCT;
        shift_buf <= '0;
        digit_cnt <= '0;
      end else if (key_valid) begin
        if (is_digit) begin
          if (digit_cnt != field_limit) begin
            shift_buf <= {shift_buf[BUF_W-5:0], key_code};
            digit_cnt <= digit_cnt + 1'b1;
          end
        end else begin
          case (key_code)
            4'hA: begin
              shift_buf <= '0;
              digit_cnt <= '0;
            end
            4'hB: begin
              case (phase_reg)
                PH_ACCT: begin
                  if (digit_cnt == CNT_W'(ACCT_DIGITS)) begin
                    useractno <= shift_buf[4*ACCT_DIGITS-1:0];
                    acct_vld  <= 1'b1;
                    phase_reg <= PH_PSWD;
                    shift_buf <= '0;
                    digit_cnt <= '0;
                  end else begin
                    entry_err <= 1'b1;
                  end
                end
                PH_PSWD: begin
                  if (digit_cnt == CNT_W'(PSWD_DIGITS)) begin
                    userpswd  <= shift_buf[4*PSWD_DIGITS-1:0];
                    pswd_vld  <= 1'b1;
                    phase_reg <= PH_AMT;
                    shift_buf <= '0;
                    digit_cnt <= '0;
                  end else begin
                    entry_err <= 1'b1;
                  end
                end
                default: begin
                  // Amount is variable length; phase stays AMT so further
                  // withdrawals can follow without re-entering credentials.
                  if (digit_cnt != '0) begin
                    useramt   <= shift_buf[4*AMT_DIGITS-1:0];
                    amt_vld   <= 1'b1;
                    shift_buf <= '0;
                    digit_cnt <= '0;
                  end else begin
                    entry_err <= 1'b1;
                  end
                end
              endcase
            end
            4'hC: begin
              useractno <= '0;
              userpswd  <= '0;
              useramt   <= '0;
              shift_buf <= '0;
              digit_cnt <= '0;
              phase_reg <= PH_ACCT;
            end
            default: ; // D-F: no effect on entry state
          endcase
        end
      end else if (expire) begin
        // Inactivity abort behaves exactly like Cancel.
        useractno <= '0;
        userpswd  <= '0;
        useramt   <= '0;
        shift_buf <= '0;
        digit_cnt <= '0;
        phase_reg <= PH_ACCT;
      end
    end
  end

`ifdef ATM_KEY_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             active;

  // Idle in ACCT with nothing typed is not a pending transaction.
  assign active = (phase_reg != PH_ACCT) || (digit_cnt != '0);
  // A key on the expiry cycle takes precedence over the abort.
  assign expire = !key_valid && active && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (key_valid || expire) begin
        tmo_cnt <= '0;
      end else if (active) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

endmodule
